// File: rtl/grid_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grid_read_arbiter
// Purpose  : Shares the grid-map BRAM read port between the DDA stepper and
//            the transform logic, with map offsetting and tagged returns.
// Revision : 1.0 - initial release
// ============================================================================
module grid_read_arbiter #(
    parameter int          N              = 24,
    parameter int          NUM_MAPS       = 4,
    parameter int          READ_LAT       = 2,
    parameter int          MAX_DDA_STREAK = 8,
    parameter logic [3:0]  OOB_DATA       = 4'd1,
    localparam int         CELL_AW        = $clog2(N*N),
    localparam int         BRAM_AW        = $clog2(NUM_MAPS*N*N)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [1:0]         map_select,
    input  logic               dda_req_in,
    input  logic [CELL_AW-1:0] dda_addr_in,
    output logic               dda_gnt_out,
    output logic               dda_valid_out,
    input  logic               trans_req_in,
    input  logic [CELL_AW-1:0] trans_addr_in,
    output logic               trans_gnt_out,
    output logic               trans_valid_out,
    output logic [3:0]         grid_data_out,
    output logic [BRAM_AW-1:0] bram_addr_out,
    input  logic [3:0]         bram_data_in,
    output logic [1:0]         map_active_out,
    output logic               map_switch_done_out,
    output logic               busy_out
);

    localparam int C_CELLS    = N*N;
    localparam int C_STREAK_W = $clog2(MAX_DDA_STREAK+1);

    logic [1:0]            r_map_active;
    logic                  r_switch_pending;
    logic [C_STREAK_W-1:0] r_streak;
    logic [READ_LAT:0]     r_tag_live;
    logic [READ_LAT:0]     r_tag_trans;
    logic [READ_LAT:0]     r_tag_oob;

    logic                  w_grant_ok;
    logic                  w_streak_full;
    logic                  w_trans_wins;
    logic                  w_dda_gnt;
    logic                  w_trans_gnt;
    logic                  w_xfer;
    logic [CELL_AW-1:0]    w_sel_addr;
    logic                  w_oob;
    logic [BRAM_AW-1:0]    w_map_base;
    logic                  w_switch_commit;
    logic                  w_switch_req;

    // Grants are also masked while reset is held so every output reads 0.
    assign w_grant_ok    = rst_in && !r_switch_pending;
    assign w_streak_full = (r_streak == C_STREAK_W'(MAX_DDA_STREAK));
    assign w_trans_wins  = trans_req_in && (!dda_req_in || w_streak_full);
    assign w_dda_gnt     = w_grant_ok && dda_req_in && !w_trans_wins;
    assign w_trans_gnt   = w_grant_ok && w_trans_wins;
    assign w_xfer        = w_dda_gnt || w_trans_gnt;

    assign w_sel_addr      = w_trans_gnt ? trans_addr_in : dda_addr_in;
    assign w_oob           = ({1'b0, w_sel_addr} >= (CELL_AW+1)'(C_CELLS));
    assign w_map_base      = BRAM_AW'(r_map_active) * BRAM_AW'(C_CELLS);
    assign w_switch_commit = r_switch_pending && !(|r_tag_live);
    assign w_switch_req    = (map_select != r_map_active) && !r_switch_pending;

    assign dda_gnt_out    = w_dda_gnt;
    assign trans_gnt_out  = w_trans_gnt;
    assign map_active_out = r_map_active;
    assign busy_out       = (|r_tag_live) || r_switch_pending;

    // Starvation guard: counts DDA wins only while transform is waiting.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_streak <= '0;
        end else if (w_trans_gnt || !trans_req_in) begin
            r_streak <= '0;
        end else if (w_dda_gnt) begin
            r_streak <= r_streak + C_STREAK_W'(1);
        end
    end

    // Map switch waits for the read pipeline to drain; latest select wins.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_map_active        <= '0;
            r_switch_pending    <= 1'b0;
            map_switch_done_out <= 1'b0;
        end else begin
            map_switch_done_out <= 1'b0;
            if (w_switch_commit) begin
                r_map_active        <= map_select;
                r_switch_pending    <= 1'b0;
                map_switch_done_out <= 1'b1;
            end else if (w_switch_req) begin
                r_switch_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bram_addr_out <= '0;
            r_tag_live    <= '0;
            r_tag_trans   <= '0;
            r_tag_oob     <= '0;
        end else begin
            if (w_xfer) begin
                bram_addr_out <= w_map_base + BRAM_AW'(w_sel_addr);
            end
            r_tag_live  <= {r_tag_live[READ_LAT-1:0],  w_xfer};
            r_tag_trans <= {r_tag_trans[READ_LAT-1:0], w_trans_gnt};
            r_tag_oob   <= {r_tag_oob[READ_LAT-1:0],   w_oob};
        end
    end

    // The oldest tag lines up with the BRAM data of its read.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            grid_data_out   <= '0;
            dda_valid_out   <= 1'b0;
            trans_valid_out <= 1'b0;
        end else begin
            dda_valid_out   <= r_tag_live[READ_LAT] && !r_tag_trans[READ_LAT];
            trans_valid_out <= r_tag_live[READ_LAT] &&  r_tag_trans[READ_LAT];
            if (r_tag_live[READ_LAT]) begin
                grid_data_out <= r_tag_oob[READ_LAT] ? OOB_DATA : bram_data_in;
            end
        end
    end

endmodule
`default_nettype wire
